id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage sitting directly downstream of the register file. Captures operands read from the register file together with decoded control into the ID/EX pipeline register. Handles three things locally:
- same-cycle writeback bypass, since a register file write and a read of the same register in one cycle return stale data;
- load-use interlock with bubble insertion;
- flush.

Keeps a saturating count of interlock stall cycles for performance monitoring.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/id_hazard_unit.sv | 33 +++
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline widths, the ID/EX bundle and the operand-select helper
// used by decode and execute.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int CTRL_W  = 16;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [CTRL_W-1:0]  ctrl;
        logic               is_load;
        logic               reg_write;
    } ex_bundle_t;

    function automatic logic wb_hits(
        input logic               wb_reg_write,
        input logic [RADDR_W-1:0] wb_rd,
        input logic [RADDR_W-1:0] idx
    );
        return wb_reg_write && wb_rd != '0 && wb_rd == idx;
    endfunction

    // x0 reads as zero even if the register file or writeback says otherwise
    function automatic logic [XLEN-1:0] operand(
        input logic [RADDR_W-1:0] idx,
        input logic [XLEN-1:0]    rdata,
        input logic               wb_reg_write,
        input logic [RADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]    wb_data
    );
        return idx == '0 ? '0 : wb_hits(wb_reg_write, wb_rd, idx) ? wb_data : rdata;
    endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: combinational load-use detection and same-cycle writeback bypass
// for the two decode operands.
module id_hazard_unit
    import cpu_pkg::*;
(
    input  logic               ex_valid,
    input  logic               ex_is_load,
    input  logic               ex_reg_write,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               id_valid,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               lu,
    output logic [XLEN-1:0]    op1,
    output logic [XLEN-1:0]    op2
);

    logic load_in_ex;

    assign load_in_ex = ex_valid && ex_is_load && ex_reg_write && ex_rd != '0;
    assign lu = load_in_ex && id_valid &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign op1 = operand(id_rs1, id_rs1_data, wb_reg_write, wb_rd, wb_data);
    assign op2 = operand(id_rs2, id_rs2_data, wb_reg_write, wb_rd, wb_data);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with writeback bypass, load-use bubble,
// flush, held-operand refresh and a saturating stall counter.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic               id_is_load,
    input  logic               id_reg_write,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic               ex_is_load,
    output logic               ex_reg_write,
    output logic [15:0]        stall_cnt
);

    ex_bundle_t      ex_q;
    ex_bundle_t      id_bundle;
    logic            adv;
    logic            lu;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    id_hazard_unit u_hazard (
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_q.is_load),
        .ex_reg_write (ex_q.reg_write),
        .ex_rd        (ex_q.rd),
        .id_valid     (id_valid),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu           (lu),
        .op1          (op1),
        .op2          (op2)
    );

    assign adv      = !ex_valid || ex_ready;
    assign id_ready = flush || (adv && !lu);

    assign id_bundle = '{pc: id_pc, imm: id_imm, rs1_data: op1, rs2_data: op2,
                         rs1: id_rs1, rs2: id_rs2, rd: id_rd, ctrl: id_ctrl,
                         is_load: id_is_load, reg_write: id_reg_write};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_q      <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush || (adv && (lu || !id_valid))) begin
                ex_valid <= 1'b0;
            end else if (adv) begin
                ex_valid <= 1'b1;
                ex_q     <= id_bundle;
            end else begin
                // a held instruction must still see writebacks that land while it waits
                if (wb_hits(wb_reg_write, wb_rd, ex_q.rs1)) ex_q.rs1_data <= wb_data;
                if (wb_hits(wb_reg_write, wb_rd, ex_q.rs2)) ex_q.rs2_data <= wb_data;
            end
            if (lu && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_is_load   = ex_q.is_load;
    assign ex_reg_write = ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table plus hand-written load-use, hold, flush,
// reset and saturation sequences for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0, id_ready;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_is_load = 1'b0, id_reg_write = 1'b0;
    logic [15:0] id_ctrl = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0, ex_ready = 1'b1;
    logic        ex_valid, ex_is_load, ex_reg_write;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl, stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2;
        logic [31:0] d1, d2, imm;
        logic [15:0] ctrl;
        logic        ld, rw;
        logic        wbe;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic [31:0] exp1, exp2;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic ld);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = pc ^ 32'hFFFF_0000; id_ctrl = pc[15:0] + 16'h0101;
        id_is_load = ld; id_reg_write = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{32'h100, 5'd1,  5'd2,  5'd3,  1, 1, 32'h11, 32'h22, 32'h7,  16'hA001, 0, 1, 0, 5'd0, 32'h0,         32'h11,        32'h22};
        vt[1] = '{32'h104, 5'd4,  5'd6,  5'd8,  1, 1, 32'h44, 32'h66, 32'h8,  16'hA002, 0, 1, 0, 5'd0, 32'h0,         32'h44,        32'h66};
        vt[2] = '{32'h108, 5'd9,  5'd10, 5'd11, 1, 0, 32'h99, 32'hAA, 32'h9,  16'hA003, 0, 0, 0, 5'd0, 32'h0,         32'h99,        32'hAA};
        vt[3] = '{32'h10C, 5'd12, 5'd13, 5'd14, 0, 1, 32'hCC, 32'hDD, 32'hA,  16'hA004, 0, 1, 0, 5'd0, 32'h0,         32'hCC,        32'hDD};
        vt[4] = '{32'h110, 5'd5,  5'd6,  5'd1,  1, 1, 32'h1,  32'h2,  32'hB,  16'hA005, 0, 1, 1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2};
        vt[5] = '{32'h114, 5'd5,  5'd6,  5'd1,  1, 1, 32'h1,  32'h2,  32'hC,  16'hA006, 0, 1, 1, 5'd0, 32'hDEAD_BEEF, 32'h1,         32'h2};
        vt[6] = '{32'h118, 5'd0,  5'd0,  5'd1,  1, 1, 32'h1,  32'h77, 32'hD,  16'hA007, 0, 1, 1, 5'd5, 32'hDEAD_BEEF, 32'h0,         32'h0};
        vt[7] = '{32'h11C, 5'd9,  5'd9,  5'd2,  1, 1, 32'h3,  32'h4,  32'hE,  16'hA008, 0, 1, 1, 5'd9, 32'h1234,      32'h1234,      32'h1234};
        vt[8] = '{32'h120, 5'd1,  5'd2,  5'd20, 1, 0, 32'h5,  32'h6,  32'hF,  16'hA009, 1, 1, 0, 5'd0, 32'h0,         32'h5,         32'h6};
        vt[9] = '{32'h124, 5'd1,  5'd20, 5'd21, 1, 0, 32'h7,  32'h8,  32'h10, 16'hA00A, 0, 1, 0, 5'd0, 32'h0,         32'h7,         32'h8};

        #2;
        chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset ex_pc", ex_pc, 32'd0);
        chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            id_valid = 1'b1; id_pc = vt[i].pc; id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; id_rd = vt[i].rd;
            id_use_rs1 = vt[i].use1; id_use_rs2 = vt[i].use2; id_rs1_data = vt[i].d1; id_rs2_data = vt[i].d2;
            id_imm = vt[i].imm; id_ctrl = vt[i].ctrl; id_is_load = vt[i].ld; id_reg_write = vt[i].rw;
            wb_reg_write = vt[i].wbe; wb_rd = vt[i].wbr; wb_data = vt[i].wbd;
            #1;
            chk($sformatf("v%0d id_ready", i), {31'd0, id_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("v%0d ex_pc", i), ex_pc, vt[i].pc);
            chk($sformatf("v%0d ex_rs1_data", i), ex_rs1_data, vt[i].exp1);
            chk($sformatf("v%0d ex_rs2_data", i), ex_rs2_data, vt[i].exp2);
            chk($sformatf("v%0d ex_imm", i), ex_imm, vt[i].imm);
            chk($sformatf("v%0d ex_ctrl", i), {16'd0, ex_ctrl}, {16'd0, vt[i].ctrl});
            chk($sformatf("v%0d ex_idx", i), {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, vt[i].rs1, vt[i].rs2, vt[i].rd});
            chk($sformatf("v%0d ex_flags", i), {30'd0, ex_is_load, ex_reg_write}, {30'd0, vt[i].ld, vt[i].rw});
        end
        chk("table stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // load-use: one bubble then capture
        @(negedge clk);
        wb_reg_write = 1'b0;
        drive(32'h300, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0, 1);
        tick();
        @(negedge clk);
        drive(32'h304, 5'd1, 5'd7, 5'd8, 1, 1, 32'h11, 32'h77, 0);
        #1;
        chk("lu id_ready low", {31'd0, id_ready}, 32'd0);
        tick();
        chk("lu bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
        @(negedge clk);
        #1;
        chk("lu id_ready recovers", {31'd0, id_ready}, 32'd1);
        tick();
        chk("lu capture valid", {31'd0, ex_valid}, 32'd1);
        chk("lu capture pc", ex_pc, 32'h304);
        chk("lu capture rs2", ex_rs2_data, 32'h77);
        chk("lu stall_cnt after", {16'd0, stall_cnt}, 32'd1);

        // held EX with writebacks refreshing rs1
        @(negedge clk);
        drive(32'h200, 5'd3, 5'd4, 5'd9, 1, 1, 32'h10, 32'h20, 0);
        tick();
        @(negedge clk);
        drive(32'h204, 5'd1, 5'd2, 5'd9, 1, 1, 32'h1, 32'h2, 0);
        ex_ready = 1'b0; wb_reg_write = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
        #1;
        chk("hold id_ready", {31'd0, id_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold%0d valid", k), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("hold%0d pc", k), ex_pc, 32'h200);
            chk($sformatf("hold%0d rs1_data", k), ex_rs1_data, 32'h55);
            chk($sformatf("hold%0d rs2_data", k), ex_rs2_data, 32'h20);
            chk($sformatf("hold%0d rd", k), {27'd0, ex_rd}, 32'd9);
        end
        @(negedge clk);
        wb_reg_write = 1'b0; ex_ready = 1'b1;
        tick();
        chk("hold release pc", ex_pc, 32'h204);

        // flush beats a load-use stall
        @(negedge clk);
        drive(32'h400, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0, 1);
        tick();
        @(negedge clk);
        drive(32'h404, 5'd7, 5'd2, 5'd8, 1, 0, 32'h1, 32'h2, 0);
        flush = 1'b1;
        #1;
        chk("flush id_ready", {31'd0, id_ready}, 32'd1);
        tick();
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush stall_cnt", {16'd0, stall_cnt}, 32'd1);
        @(negedge clk);
        flush = 1'b0;

        // async reset in the middle of a stall
        drive(32'h500, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0, 1);
        tick();
        @(negedge clk);
        drive(32'h504, 5'd7, 5'd2, 5'd8, 1, 0, 32'h1, 32'h2, 0);
        ex_ready = 1'b0;
        tick();
        tick();
        chk("stall before reset", {16'd0, stall_cnt}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst ex_pc", ex_pc, 32'd0);
        chk("rst ex_flags", {30'd0, ex_is_load, ex_reg_write}, 32'd0);
        chk("rst ex_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // saturate the counter with a permanently held hazard
        ex_ready = 1'b1;
        drive(32'h600, 5'd1, 5'd2, 5'd7, 0, 0, 0, 0, 1);
        tick();
        @(negedge clk);
        drive(32'h604, 5'd7, 5'd2, 5'd8, 1, 0, 32'h1, 32'h2, 0);
        ex_ready = 1'b0;
        begin
            int n = 0;
            while (stall_cnt != 16'hFFFE && n < 70000) begin
                tick();
                n++;
            end
        end
        chk("sat reach FFFE", {16'd0, stall_cnt}, 32'h0000_FFFE);
        tick();
        chk("sat FFFF", {16'd0, stall_cnt}, 32'h0000_FFFF);
        repeat (3) tick();
        chk("sat hold FFFF", {16'd0, stall_cnt}, 32'h0000_FFFF);
        chk("sat load held", {30'd0, ex_valid, ex_is_load}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
